// File: rtl/acc_core_if.sv
// Instruction-fetch port of acc_core: the core is the master, instruction memory the slave.
// An instruction is accepted on a rising edge where imem_req && imem_valid; imem_data is ignored otherwise.
interface acc_core_if #(
  parameter int PC_W   = 8,
  parameter int ADDR_W = 4
);
  logic [PC_W-1:0]   imem_addr;
  logic              imem_req;
  logic [ADDR_W+3:0] imem_data;
  logic              imem_valid;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_data,
    input  imem_valid
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_data,
    output imem_valid
  );
endinterface

// File: rtl/acc_core.sv
// Accumulator instruction-execute core: FETCH/EXEC/DIV/HALT FSM with ACC, EXT, carry and register file.
// Define ACC_CORE_DIV_EN to build the multi-cycle restoring divider; otherwise opcode 4 is a NOP.
module acc_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  acc_core_if.master        imem,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] ext,
  output logic              carry,
  output logic              busy,
  output logic              hlt,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_DIV   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_ALU1 = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_DIV  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_CMP  = 4'h7;
  localparam logic [3:0] OP_JC   = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_OR   = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hF;

  state_t              state_q, state_d;
  logic [ADDR_W+3:0]   ir_q, ir_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   ext_q, ext_d;
  logic                carry_q, carry_d;
  logic                hlt_q, hlt_d;
  logic [DATA_W-1:0]   rf_q [2**ADDR_W];
  logic                rf_we;

  logic [3:0]          opc;
  logic [ADDR_W-1:0]   opnd;
  logic [DATA_W-1:0]   r_val;
  logic [PC_W-1:0]     pc_inc;
  logic [DATA_W:0]     add_sum;
  logic [DATA_W:0]     inc_sum;
  logic [2*DATA_W-1:0] prod;

  assign opc     = ir_q[ADDR_W+3:ADDR_W];
  assign opnd    = ir_q[ADDR_W-1:0];
  assign r_val   = rf_q[opnd];
  assign pc_inc  = pc_q + PC_W'(1);
  assign add_sum = {1'b0, acc_q} + {1'b0, r_val};
  assign inc_sum = {1'b0, acc_q} + (DATA_W+1)'(1);
  assign prod    = (2*DATA_W)'(acc_q) * (2*DATA_W)'(r_val);

`ifdef ACC_CORE_DIV_EN
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  logic [DATA_W-1:0] div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W:0]   rem_sh;
  logic              rem_ge;

  // ext holds the partial remainder and acc shifts dividend bits out / quotient bits in.
  assign rem_sh = {ext_q, acc_q[DATA_W-1]};
  assign rem_ge = (rem_sh >= {1'b0, div_q});
  assign busy   = (state_q == S_DIV);
`else
  assign busy   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ext_d   = ext_q;
    carry_d = carry_q;
    hlt_d   = hlt_q;
    rf_we   = 1'b0;
`ifdef ACC_CORE_DIV_EN
    div_d   = div_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (imem.imem_valid) begin
          ir_d    = imem.imem_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (opc)
          OP_ALU1: begin
            case (opnd)
              ADDR_W'(1): acc_d = {acc_q[DATA_W-2:0], 1'b0};
              ADDR_W'(2): acc_d = {1'b0, acc_q[DATA_W-1:1]};
              ADDR_W'(3): acc_d = {acc_q[0], acc_q[DATA_W-1:1]};
              ADDR_W'(4): acc_d = {acc_q[DATA_W-2:0], acc_q[DATA_W-1]};
              ADDR_W'(5): acc_d = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
              ADDR_W'(6): {carry_d, acc_d} = inc_sum;
              ADDR_W'(7): begin
                acc_d   = acc_q - DATA_W'(1);
                carry_d = (acc_q == '0);
              end
              default: ;
            endcase
          end
          OP_ADD: {carry_d, acc_d} = add_sum;
          OP_SUB: begin
            acc_d   = acc_q - r_val;
            carry_d = (acc_q < r_val);
          end
          OP_MUL: {ext_d, acc_d} = prod;
`ifdef ACC_CORE_DIV_EN
          OP_DIV: begin
            // A zero divisor runs the same loop: quotient saturates to all ones, remainder ends as the dividend.
            state_d = S_DIV;
            pc_d    = pc_q;
            ext_d   = '0;
            div_d   = r_val;
            cnt_d   = '0;
            if (r_val == '0) carry_d = 1'b1;
          end
`endif
          OP_AND: acc_d   = acc_q & r_val;
          OP_XOR: acc_d   = acc_q ^ r_val;
          OP_OR:  acc_d   = acc_q | r_val;
          OP_CMP: carry_d = (acc_q < r_val);
          OP_JC:  if (carry_q) pc_d = PC_W'(opnd);
          OP_LD:  acc_d   = r_val;
          OP_ST:  rf_we   = 1'b1;
          OP_JMP: pc_d    = PC_W'(opnd);
          OP_HLT: begin
            hlt_d   = 1'b1;
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end
      S_DIV: begin
`ifdef ACC_CORE_DIV_EN
        acc_d = {acc_q[DATA_W-2:0], rem_ge};
        ext_d = rem_ge ? (rem_sh[DATA_W-1:0] - div_q) : rem_sh[DATA_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W-1)) begin
          state_d = S_FETCH;
          pc_d    = pc_inc;
        end
`else
        state_d = S_FETCH;
`endif
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      pc_q    <= '0;
      acc_q   <= '0;
      ext_q   <= '0;
      carry_q <= 1'b0;
      hlt_q   <= 1'b0;
`ifdef ACC_CORE_DIV_EN
      div_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ext_q   <= ext_d;
      carry_q <= carry_d;
      hlt_q   <= hlt_d;
`ifdef ACC_CORE_DIV_EN
      div_q   <= div_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[opnd] <= acc_q;
    end
  end

  assign imem.imem_addr = pc_q;
  assign imem.imem_req  = (state_q == S_FETCH);
  assign pc             = pc_q;
  assign acc            = acc_q;
  assign ext            = ext_q;
  assign carry          = carry_q;
  assign hlt            = hlt_q;
  assign dbg_state_o    = state_q;

endmodule
